// File: rtl/a_fifo.sv
// a_fifo: single-clock FIFO, WIDTH-bit words, DEPTH entries.
// Each pointer carries an extra wrap bit above the address bits.
// Matching addresses with equal wrap bits mean the FIFO is empty.
// Matching addresses with different wrap bits mean it is full.
// Read data is registered and changes only on an accepted read or on reset.
module a_fifo #(
  parameter int WIDTH    = 1,
  parameter int DEPTH    = 4,
  parameter int PTR_SIZE = 3
) (
  input  logic             clk_a,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_SIZE-1:0] wr_ptr;
  logic [PTR_SIZE-1:0] rd_ptr;
  logic                wr_acc;
  logic                rd_acc;

  // Flags and accept qualifiers, decoded from the registered pointers
  always_comb begin
    empty  = (wr_ptr == rd_ptr);
    full   = (wr_ptr[PTR_SIZE-1] != rd_ptr[PTR_SIZE-1]) &&
             (wr_ptr[PTR_SIZE-2:0] == rd_ptr[PTR_SIZE-2:0]);
    wr_acc = wr_en && !full;
    rd_acc = rd_en && !empty;
  end

  // Pointer, storage and read-data update; reset clears everything at once
  always_ff @(posedge clk_a or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
      mem     <= '{default: '0};
    end else begin
      if (wr_acc) begin
        mem[wr_ptr[PTR_SIZE-2:0]] <= wr_data;
        wr_ptr                    <= wr_ptr + PTR_SIZE'(1);
      end
      if (rd_acc) begin
        rd_data <= mem[rd_ptr[PTR_SIZE-2:0]];
        rd_ptr  <= rd_ptr + PTR_SIZE'(1);
      end
    end
  end

endmodule

// File: tb/tb_a_fifo.sv
// Bench for a_fifo: directed scenarios plus random traffic, checked against a queue model.
module tb_a_fifo;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk_a = 1'b0;
  logic         rst;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] wr_data;
  logic [W-1:0] rd_data;
  logic         full;
  logic         empty;

  int unsigned  total  = 0;
  int unsigned  passed = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] rd_exp;

  a_fifo #(.WIDTH(W), .DEPTH(D), .PTR_SIZE(3)) dut (
    .clk_a   (clk_a),
    .rst     (rst),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  always #5 clk_a = ~clk_a;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rd_data"}, rd_data, rd_exp);
    check({tag, ".empty"}, W'(empty), W'(q.size() == 0));
    check({tag, ".full"}, W'(full), W'(q.size() == D));
  endtask

  // One clock cycle of traffic; the model decides acceptance from the pre-edge occupancy
  task automatic cycle(input string tag, input logic w, input logic r, input logic [W-1:0] d);
    bit racc;
    bit wacc;
    wr_en   = w;
    rd_en   = r;
    wr_data = d;
    racc = r && (q.size() != 0);
    wacc = w && (q.size() != D);
    @(posedge clk_a);
    if (racc) rd_exp = q.pop_front();
    if (wacc) q.push_back(d);
    #1;
    check_outputs(tag);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any clock edge
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    q.delete();
    rd_exp = '0;
    #1;
    check_outputs(tag);
    @(posedge clk_a);
    #1;
    check_outputs({tag, ".held"});
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] fill_pat [4];
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    rd_exp  = '0;
    #3;
    check_outputs("por");
    @(posedge clk_a);
    #1;
    rst = 1'b0;

    // Reset mid-stream with two entries stored
    cycle("pre_rst_w0", 1'b1, 1'b0, 8'hA5);
    cycle("pre_rst_w1", 1'b1, 1'b0, 8'h3C);
    async_reset("mid_rst");
    cycle("post_rst_rd0", 1'b0, 1'b1, '0);
    cycle("post_rst_rd1", 1'b0, 1'b1, '0);

    // Pulse traffic with read always requested
    for (int i = 0; i < 10; i++) begin
      cycle("pulse_wr", 1'b1, 1'b1, 8'h01);
      cycle("pulse_idle", 1'b0, 1'b1, '0);
    end

    // Fill to full, drop a fifth write, drain in order
    fill_pat = '{8'h01, 8'h00, 8'h01, 8'h01};
    for (int i = 0; i < 4; i++) cycle("fill_wr", 1'b1, 1'b0, fill_pat[i]);
    cycle("fill_drop", 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) cycle("fill_rd", 1'b0, 1'b1, '0);

    // Underflow holds rd_data; a later write/read still works
    for (int i = 0; i < 3; i++) cycle("uflow_rd", 1'b0, 1'b1, '0);
    cycle("uflow_wr", 1'b1, 1'b0, 8'h5A);
    cycle("uflow_rd_ok", 1'b0, 1'b1, '0);

    // Simultaneous access when full, then when empty
    for (int i = 0; i < 4; i++) cycle("sim_fill", 1'b1, 1'b0, W'($urandom));
    cycle("sim_full", 1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < 3; i++) cycle("sim_drain", 1'b0, 1'b1, '0);
    cycle("sim_empty", 1'b1, 1'b1, 8'h77);
    cycle("sim_empty_rd", 1'b0, 1'b1, '0);

    // Wrap-around: 12 write/read pairs, alternating data, three pointer wraps
    for (int i = 0; i < 12; i++) begin
      cycle("wrap_wr", 1'b1, 1'b0, (i % 2 == 0) ? 8'hAA : 8'h55);
      cycle("wrap_rd", 1'b0, 1'b1, '0);
    end

    // Random traffic
    for (int i = 0; i < 300; i++)
      cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom));

    // Reset again under random occupancy, then more random traffic
    async_reset("rand_rst");
    for (int i = 0; i < 100; i++)
      cycle("rand2", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
